// File: rtl/enemy_array.sv
// -----------------------------------------------------------------------------
// enemy_array
// Multi-slot walker controller. Each of NUM_ENEMIES slots runs a small
// IDLE -> WALK -> SQUASH -> IDLE life cycle. A walking slot patrols
// horizontally between X_MIN and X_MAX and turns around at either bound. A
// stomped slot stays squashed for SQUASH_FRAMES frame ticks before it can be
// respawned. One walk animation bit is shared by every slot.
//
// Ports
//   Clk, Reset_n              clock, asynchronous active-low reset
//   frame_tick                one-cycle pulse per video frame
//   freeze                    game paused: nothing moves, counts, spawns or dies
//   spawn_valid/id/x/y/dir    spawn request (x is clamped to the patrol range)
//   spawn_ready               selected slot is IDLE and the game is not frozen
//   kill_valid/kill_id        stomp event on one slot
//   alive, squash, dir        per-slot WALK flag, SQUASH flag, direction
//   pos_x, pos_y              per-slot coordinates, slot i at [i*X_W +: X_W]
//   anim_frame                shared walk animation bit
//   kill_count                accepted kills since reset, saturates at 255
//   active_count              registered number of walking slots
// -----------------------------------------------------------------------------
module enemy_array #(
  parameter int NUM_ENEMIES   = 4,
  parameter int X_W           = 10,
  parameter int SPEED         = 1,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 623,
  parameter int ANIM_DIV      = 8,
  parameter int SQUASH_FRAMES = 30,
  parameter int ID_W          = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1,
  parameter int CNT_W         = $clog2(NUM_ENEMIES + 1)
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_tick,
  input  logic                       freeze,
  input  logic                       spawn_valid,
  input  logic [ID_W-1:0]            spawn_id,
  input  logic [X_W-1:0]             spawn_x,
  input  logic [X_W-1:0]             spawn_y,
  input  logic                       spawn_dir,
  output logic                       spawn_ready,
  input  logic                       kill_valid,
  input  logic [ID_W-1:0]            kill_id,
  output logic [NUM_ENEMIES-1:0]     alive,
  output logic [NUM_ENEMIES-1:0]     squash,
  output logic [NUM_ENEMIES*X_W-1:0] pos_x,
  output logic [NUM_ENEMIES*X_W-1:0] pos_y,
  output logic [NUM_ENEMIES-1:0]     dir,
  output logic                       anim_frame,
  output logic [7:0]                 kill_count,
  output logic [CNT_W-1:0]           active_count
);

  // Movement math is done one bit wider than the coordinate so x+SPEED
  // near the top of the range cannot wrap.
  localparam int XE_W = X_W + 1;
  localparam int AN_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int SQ_W = (SQUASH_FRAMES > 1) ? $clog2(SQUASH_FRAMES) : 1;

  localparam logic [XE_W-1:0] XMIN_E    = XE_W'(X_MIN);
  localparam logic [XE_W-1:0] XMAX_E    = XE_W'(X_MAX);
  localparam logic [XE_W-1:0] SPEED_E   = XE_W'(SPEED);
  localparam logic [XE_W-1:0] ONE_E     = XE_W'(1);
  localparam logic [AN_W-1:0] ANIM_LAST = AN_W'(ANIM_DIV - 1);
  localparam logic [SQ_W-1:0] SQ_LAST   = SQ_W'(SQUASH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_SQUASH = 2'd2
  } state_e;

  state_e            state_q [NUM_ENEMIES];
  state_e            state_d [NUM_ENEMIES];
  logic [X_W-1:0]    x_q     [NUM_ENEMIES];
  logic [X_W-1:0]    x_d     [NUM_ENEMIES];
  logic [X_W-1:0]    y_q     [NUM_ENEMIES];
  logic [X_W-1:0]    y_d     [NUM_ENEMIES];
  logic              dir_q   [NUM_ENEMIES];
  logic              dir_d   [NUM_ENEMIES];
  logic [SQ_W-1:0]   sq_cnt_q[NUM_ENEMIES];
  logic [SQ_W-1:0]   sq_cnt_d[NUM_ENEMIES];

  logic [AN_W-1:0]   anim_cnt_q, anim_cnt_d;
  logic              anim_q, anim_d;
  logic [7:0]        kills_q, kills_d;
  logic [CNT_W-1:0]  active_q, active_d;

  logic              tick_s;
  logic              spawn_fire_s;
  logic              kill_any_s;
  logic [XE_W-1:0]   spawn_xe_s;
  logic [X_W-1:0]    spawn_xc_s;

  assign tick_s       = frame_tick & ~freeze;
  assign spawn_fire_s = spawn_valid & spawn_ready;
  assign spawn_xe_s   = {1'b0, spawn_x};

  // Spawn readiness: addressed slot exists, is IDLE, and the game runs.
  always_comb begin
    spawn_ready = 1'b0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if ((spawn_id == ID_W'(i)) && (state_q[i] == ST_IDLE) && !freeze) begin
        spawn_ready = 1'b1;
      end else begin
        spawn_ready = spawn_ready;
      end
    end
  end

  // Clamp the requested spawn X into the patrol range; x+1 <= X_MIN is
  // used for x < X_MIN so that X_MIN = 0 does not give a constant compare.
  always_comb begin
    if (spawn_xe_s + ONE_E <= XMIN_E) begin
      spawn_xc_s = XMIN_E[X_W-1:0];
    end else if (spawn_xe_s > XMAX_E) begin
      spawn_xc_s = XMAX_E[X_W-1:0];
    end else begin
      spawn_xc_s = spawn_x;
    end
  end

  // Per-slot life cycle, patrol movement and squash timer.
  always_comb begin
    kill_any_s = 1'b0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      state_d[i]  = state_q[i];
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      dir_d[i]    = dir_q[i];
      sq_cnt_d[i] = sq_cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (spawn_fire_s && (spawn_id == ID_W'(i))) begin
            state_d[i]  = ST_WALK;
            x_d[i]      = spawn_xc_s;
            y_d[i]      = spawn_y;
            dir_d[i]    = spawn_dir;
            sq_cnt_d[i] = '0;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_WALK: begin
          // A kill on the same edge as a frame tick wins; no move that tick.
          if (kill_valid && !freeze && (kill_id == ID_W'(i))) begin
            state_d[i]  = ST_SQUASH;
            sq_cnt_d[i] = '0;
            kill_any_s  = 1'b1;
          end else if (tick_s) begin
            if (dir_q[i]) begin
              if ({1'b0, x_q[i]} + SPEED_E >= XMAX_E) begin
                x_d[i]   = XMAX_E[X_W-1:0];
                dir_d[i] = 1'b0;
              end else begin
                x_d[i] = x_q[i] + SPEED_E[X_W-1:0];
              end
            end else begin
              if ({1'b0, x_q[i]} <= XMIN_E + SPEED_E) begin
                x_d[i]   = XMIN_E[X_W-1:0];
                dir_d[i] = 1'b1;
              end else begin
                x_d[i] = x_q[i] - SPEED_E[X_W-1:0];
              end
            end
          end else begin
            state_d[i] = ST_WALK;
          end
        end
        ST_SQUASH: begin
          if (tick_s) begin
            if (sq_cnt_q[i] == SQ_LAST) begin
              state_d[i]  = ST_IDLE;
              sq_cnt_d[i] = '0;
            end else begin
              sq_cnt_d[i] = sq_cnt_q[i] + SQ_W'(1);
            end
          end else begin
            sq_cnt_d[i] = sq_cnt_q[i];
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Shared animation divider, saturating kill counter, walker popcount.
  always_comb begin
    anim_cnt_d = anim_cnt_q;
    anim_d     = anim_q;
    kills_d    = kills_q;
    active_d   = '0;
    if (tick_s) begin
      if (anim_cnt_q == ANIM_LAST) begin
        anim_cnt_d = '0;
        anim_d     = ~anim_q;
      end else begin
        anim_cnt_d = anim_cnt_q + AN_W'(1);
      end
    end else begin
      anim_cnt_d = anim_cnt_q;
    end
    if (kill_any_s && (kills_q != 8'hFF)) begin
      kills_d = kills_q + 8'd1;
    end else begin
      kills_d = kills_q;
    end
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      active_d = active_d + CNT_W'(alive[i]);
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i]  <= ST_IDLE;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
        dir_q[i]    <= 1'b0;
        sq_cnt_q[i] <= '0;
      end
      anim_cnt_q <= '0;
      anim_q     <= 1'b0;
      kills_q    <= 8'd0;
      active_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i]  <= state_d[i];
        x_q[i]      <= x_d[i];
        y_q[i]      <= y_d[i];
        dir_q[i]    <= dir_d[i];
        sq_cnt_q[i] <= sq_cnt_d[i];
      end
      anim_cnt_q <= anim_cnt_d;
      anim_q     <= anim_d;
      kills_q    <= kills_d;
      active_q   <= active_d;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    alive = '0;
    squash = '0;
    dir = '0;
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      alive[i]            = (state_q[i] == ST_WALK);
      squash[i]           = (state_q[i] == ST_SQUASH);
      dir[i]              = dir_q[i];
      pos_x[i*X_W +: X_W] = x_q[i];
      pos_y[i*X_W +: X_W] = y_q[i];
    end
  end

  assign anim_frame   = anim_q;
  assign kill_count   = kills_q;
  assign active_count = active_q;

endmodule

// File: tb/tb_enemy_array.sv
// -----------------------------------------------------------------------------
// tb_enemy_array
// Self-checking bench for enemy_array: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model of the slots.
// -----------------------------------------------------------------------------
module tb_enemy_array;
  localparam int N     = 4;
  localparam int XW    = 10;
  localparam int SPD   = 1;
  localparam int XMIN  = 0;
  localparam int XMAX  = 623;
  localparam int ADIV  = 8;
  localparam int SQF   = 30;
  localparam int IDLE  = 0;
  localparam int WALK  = 1;
  localparam int SQSH  = 2;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            frame_tick = 1'b0, freeze = 1'b0;
  logic            spawn_valid = 1'b0, spawn_dir = 1'b0;
  logic [1:0]      spawn_id = 2'd0, kill_id = 2'd0;
  logic [XW-1:0]   spawn_x = '0, spawn_y = '0;
  logic            kill_valid = 1'b0;
  logic            spawn_ready, anim_frame;
  logic [N-1:0]    alive, squash, dir;
  logic [N*XW-1:0] pos_x, pos_y;
  logic [7:0]      kill_count;
  logic [2:0]      active_count;

  enemy_array #(.NUM_ENEMIES(N), .X_W(XW), .SPEED(SPD), .X_MIN(XMIN), .X_MAX(XMAX),
                .ANIM_DIV(ADIV), .SQUASH_FRAMES(SQF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .freeze(freeze),
    .spawn_valid(spawn_valid), .spawn_id(spawn_id), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .spawn_dir(spawn_dir), .spawn_ready(spawn_ready), .kill_valid(kill_valid),
    .kill_id(kill_id), .alive(alive), .squash(squash), .pos_x(pos_x), .pos_y(pos_y),
    .dir(dir), .anim_frame(anim_frame), .kill_count(kill_count),
    .active_count(active_count));

  always #5 Clk = ~Clk;

  // Behavioural model
  int m_state[N], m_x[N], m_y[N], m_dir[N], m_sq_ticks[N];
  int m_anim_ticks, m_anim, m_kills, m_active;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = IDLE; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_sq_ticks[i] = 0;
    end
    m_anim_ticks = 0; m_anim = 0; m_kills = 0; m_active = 0;
  endtask

  function automatic int slot_x(input int i);
    logic [N*XW-1:0] v;
    v = pos_x;
    return int'(v[i*XW +: XW]);
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0]    e_alive, e_sq, e_dir;
    logic [N*XW-1:0] e_px, e_py;
    e_alive = '0; e_sq = '0; e_dir = '0; e_px = '0; e_py = '0;
    for (int i = 0; i < N; i++) begin
      e_alive[i] = (m_state[i] == WALK);
      e_sq[i]    = (m_state[i] == SQSH);
      e_dir[i]   = (m_dir[i] != 0);
      e_px[i*XW +: XW] = XW'(m_x[i]);
      e_py[i*XW +: XW] = XW'(m_y[i]);
    end
    check({tag, ".alive"},  64'(alive),        64'(e_alive));
    check({tag, ".squash"}, 64'(squash),       64'(e_sq));
    check({tag, ".dir"},    64'(dir),          64'(e_dir));
    check({tag, ".pos_x"},  64'(pos_x),        64'(e_px));
    check({tag, ".pos_y"},  64'(pos_y),        64'(e_py));
    check({tag, ".anim"},   64'(anim_frame),   64'(m_anim));
    check({tag, ".kills"},  64'(kill_count),   64'(m_kills));
    check({tag, ".active"}, 64'(active_count), 64'(m_active));
  endtask

  // One clock: drive inputs, check spawn_ready, advance the model, check outputs.
  task automatic cycle(input bit sv, input int sid, input int sx, input int sy, input bit sd,
                       input bit kv, input int kid, input bit ft, input bit fz);
    int pop;
    spawn_valid = sv; spawn_id = 2'(sid); spawn_x = XW'(sx); spawn_y = XW'(sy);
    spawn_dir = sd; kill_valid = kv; kill_id = 2'(kid); frame_tick = ft; freeze = fz;
    #1;
    check("spawn_ready", 64'(spawn_ready), 64'((m_state[sid] == IDLE) && !fz));
    pop = 0;
    for (int i = 0; i < N; i++) if (m_state[i] == WALK) pop++;
    for (int i = 0; i < N; i++) begin
      if (m_state[i] == WALK && kv && kid == i && !fz) begin
        m_state[i] = SQSH; m_sq_ticks[i] = 0;
        if (m_kills < 255) m_kills++;
      end else if (m_state[i] == WALK && ft && !fz) begin
        if (m_dir[i] == 1) begin
          if (m_x[i] + SPD >= XMAX) begin m_x[i] = XMAX; m_dir[i] = 0; end
          else m_x[i] = m_x[i] + SPD;
        end else begin
          if (m_x[i] <= XMIN + SPD) begin m_x[i] = XMIN; m_dir[i] = 1; end
          else m_x[i] = m_x[i] - SPD;
        end
      end else if (m_state[i] == SQSH && ft && !fz) begin
        m_sq_ticks[i]++;
        if (m_sq_ticks[i] >= SQF) m_state[i] = IDLE;
      end else if (m_state[i] == IDLE && sv && sid == i && !fz) begin
        m_state[i] = WALK;
        m_x[i] = (sx < XMIN) ? XMIN : ((sx > XMAX) ? XMAX : sx);
        m_y[i] = sy; m_dir[i] = sd;
      end
    end
    if (ft && !fz) begin
      m_anim_ticks++;
      if (m_anim_ticks == ADIV) begin m_anim = 1 - m_anim; m_anim_ticks = 0; end
    end
    m_active = pop;
    @(posedge Clk); #1;
    check_all("cyc");
  endtask

  task automatic tick(input bit fz);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1, fz);
  endtask

  task automatic spawn(input int id, input int x, input int y, input bit d);
    cycle(1'b1, id, x, y, d, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic kill(input int id, input bit ft);
    cycle(1'b0, id, 0, 0, 1'b0, 1'b1, id, ft, 1'b0);
  endtask

  task automatic do_reset();
    spawn_valid = 1'b0; kill_valid = 1'b0; frame_tick = 1'b0; freeze = 1'b0;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_async.alive", 64'(alive), 64'(0));
    check("rst_async.pos_x", 64'(pos_x), 64'(0));
    check("rst_async.kills", 64'(kill_count), 64'(0));
    check_all("rst_async");
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    check_all("rst_release");
  endtask

  int saved_x1, saved_x2, saved_anim;

  initial begin
    model_reset();
    @(posedge Clk); @(posedge Clk); #1;
    check_all("reset");
    Reset_n = 1'b1;

    // 1: reset mid-walk
    spawn(2, 100, 50, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0);
    check("t1.x2", 64'(slot_x(2)), 64'(105));
    #2;
    do_reset();

    // 2: right-edge bounce
    spawn(1, 620, 40, 1'b1);
    tick(1'b0); tick(1'b0); tick(1'b0);
    check("t2.x623", 64'(slot_x(1)), 64'(623));
    check("t2.dir0", 64'(dir[1]), 64'(0));
    tick(1'b0);
    check("t2.x622", 64'(slot_x(1)), 64'(622));

    // 3: left-edge bounce
    spawn(0, 1, 60, 1'b0);
    tick(1'b0);
    check("t3.x0", 64'(slot_x(0)), 64'(0));
    check("t3.dir1", 64'(dir[0]), 64'(1));
    tick(1'b0);
    check("t3.x1", 64'(slot_x(0)), 64'(1));

    // 4: kill, squash timeout, kill on idle slot
    spawn(3, 300, 70, 1'b1);
    kill(3, 1'b0);
    check("t4.alive3", 64'(alive[3]), 64'(0));
    check("t4.squash3", 64'(squash[3]), 64'(1));
    check("t4.kills1", 64'(kill_count), 64'(1));
    for (int k = 0; k < 29; k++) tick(1'b0);
    check("t4.still_squash", 64'(squash[3]), 64'(1));
    tick(1'b0);
    check("t4.squash_done", 64'(squash[3]), 64'(0));
    kill(3, 1'b0);
    check("t4.kills_hold", 64'(kill_count), 64'(1));

    // 5: kill and tick in the same cycle
    do_reset();
    spawn(0, 50, 20, 1'b1);
    kill(0, 1'b1);
    check("t5.x50", 64'(slot_x(0)), 64'(50));
    check("t5.squash0", 64'(squash[0]), 64'(1));

    // 6: freeze with two walkers, then kill-count saturation
    spawn(1, 200, 10, 1'b0);
    spawn(2, 400, 11, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b0);
    saved_x1 = m_x[1]; saved_x2 = m_x[2]; saved_anim = m_anim;
    for (int k = 0; k < 20; k++) cycle(1'b1, 3, 5, 5, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    check("t6.x1_frozen", 64'(slot_x(1)), 64'(saved_x1));
    check("t6.x2_frozen", 64'(slot_x(2)), 64'(saved_x2));
    check("t6.anim_frozen", 64'(anim_frame), 64'(saved_anim));
    check("t6.alive3_none", 64'(alive[3]), 64'(0));
    for (int it = 0; it < 75; it++) begin
      for (int s = 0; s < N; s++) spawn(s, 100 + s, s, 1'b1);
      for (int s = 0; s < N; s++) kill(s, 1'b0);
      for (int k = 0; k < SQF; k++) tick(1'b0);
    end
    check("t6.kills_sat", 64'(kill_count), 64'(255));

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
